b_row_loader: RTL and testbench

B_ROW_LOADER -- requirements
Module: b_row_loader

---
 rtl/b_row_loader.sv | 153 +++++++++++++++
 tb/tb_b_row_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/b_row_loader.sv
`default_nettype none
// ============================================================================
// Module   : b_row_loader
// Brief    : Gathers serial B-matrix entries into rows and issues them to memB;
//            optional zero-row flush enabled by macro B_LOADER_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module b_row_loader #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int ROWS    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 in_valid,
    input  logic signed [BITS_AB-1:0]            in_data,
    output logic                                 in_ready,
    output logic signed [DIM-1:0][BITS_AB-1:0]   Bin,
    output logic                                 en,
    output logic [7:0]                           row_cnt,
    output logic                                 done
);

    localparam int                  c_IDX_W    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(DIM - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [7:0]          c_ROW_LAST = 8'(ROWS - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FILL  = 3'd1;
    localparam logic [2:0] c_ISSUE = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
`ifdef B_LOADER_FLUSH_EN
    localparam logic [2:0]         c_FLUSH      = 3'd4;
    // The flush runs DIM-1 cycles, so the down-counter starts at DIM-2.
    localparam logic [c_IDX_W-1:0] c_FLUSH_LOAD = c_IDX_W'(DIM - 2);
    logic [c_IDX_W-1:0]            r_flush_cnt;
`endif

    logic [2:0]                          r_state;
    logic [2:0]                          w_state_nxt;
    logic [c_IDX_W-1:0]                  r_idx;
    logic [7:0]                          r_row_cnt;
    logic signed [DIM-1:0][BITS_AB-1:0]  r_buf;
    logic                                w_accept;

    assign w_accept = (r_state == c_FILL) && in_valid;
    assign row_cnt  = r_row_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        en          = 1'b0;
        done        = 1'b0;
        Bin         = '0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_FILL;
                end
            end
            c_FILL: begin
                in_ready = 1'b1;
                if (w_accept && (r_idx == c_IDX_LAST)) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                en  = 1'b1;
                Bin = r_buf;
                if (r_row_cnt == c_ROW_LAST) begin
`ifdef B_LOADER_FLUSH_EN
                    // A single-entry row has nothing left to flush.
                    w_state_nxt = (DIM > 1) ? c_FLUSH : c_DONE;
`else
                    w_state_nxt = c_DONE;
`endif
                end else begin
                    w_state_nxt = c_FILL;
                end
            end
`ifdef B_LOADER_FLUSH_EN
            c_FLUSH: begin
                en = 1'b1;
                if (r_flush_cnt == '0) begin
                    w_state_nxt = c_DONE;
                end
            end
`endif
            c_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf     <= '0;
            r_idx     <= '0;
            r_row_cnt <= '0;
`ifdef B_LOADER_FLUSH_EN
            r_flush_cnt <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_idx     <= '0;
                        r_row_cnt <= '0;
                    end
                end
                c_FILL: begin
                    if (w_accept) begin
                        r_buf[r_idx] <= in_data;
                        r_idx        <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
                    end
                end
                c_ISSUE: begin
                    r_row_cnt <= r_row_cnt + 8'd1;
`ifdef B_LOADER_FLUSH_EN
                    if (r_row_cnt == c_ROW_LAST) begin
                        r_flush_cnt <= c_FLUSH_LOAD;
                    end
`endif
                end
`ifdef B_LOADER_FLUSH_EN
                c_FLUSH: begin
                    if (r_flush_cnt != '0) begin
                        r_flush_cnt <= r_flush_cnt - c_IDX_ONE;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_b_row_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_b_row_loader
// Brief    : Directed table, corner sequences and random traffic for b_row_loader.
// Revision : 1.0
// ============================================================================
module tb_b_row_loader;

    localparam int BITS_AB = 8;
    localparam int DIM     = 8;
    localparam int ROWS    = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    in_valid = 1'b0;
    logic [BITS_AB-1:0]      in_data = '0;
    logic                    in_ready;
    logic [DIM-1:0][7:0]     bin;
    logic                    en;
    logic [7:0]              row_cnt;
    logic                    done;

    int checks = 0;
    int errors = 0;

    b_row_loader #(.BITS_AB(BITS_AB), .DIM(DIM), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .Bin(bin), .en(en), .row_cnt(row_cnt), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: a queue of scheduled non-fill output cycles. Empty queue means
    // either filling (matrix open) or idle.
    typedef struct {
        bit          en;
        bit          done;
        logic [63:0] bin;
        int          rc;
    } sched_t;

    sched_t             m_sched[$];
    logic [7:0]         m_row[$];
    bit                 m_matrix = 1'b0;
    int                 m_rows = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit v, input logic [7:0] d);
        sched_t rec;
        if (r) begin
            m_sched.delete();
            m_row.delete();
            m_matrix = 1'b0;
            m_rows   = 0;
        end else if (m_sched.size() > 0) begin
            void'(m_sched.pop_front());
        end else if (m_matrix) begin
            if (v) begin
                m_row.push_back(d);
                if (m_row.size() == DIM) begin
                    rec.en = 1'b1; rec.done = 1'b0; rec.rc = m_rows; rec.bin = '0;
                    for (int i = 0; i < DIM; i++) rec.bin[8*i +: 8] = m_row[i];
                    m_sched.push_back(rec);
                    m_row.delete();
                    m_rows++;
                    if (m_rows == ROWS) begin
                        m_matrix = 1'b0;
`ifdef B_LOADER_FLUSH_EN
                        for (int i = 0; i < DIM - 1; i++) begin
                            rec.en = 1'b1; rec.done = 1'b0; rec.rc = m_rows; rec.bin = '0;
                            m_sched.push_back(rec);
                        end
`endif
                        rec.en = 1'b0; rec.done = 1'b1; rec.rc = m_rows; rec.bin = '0;
                        m_sched.push_back(rec);
                    end
                end
            end
        end else if (s) begin
            m_matrix = 1'b1;
            m_rows   = 0;
            m_row.delete();
        end
    endtask

    task automatic model_check();
        bit          e_rdy, e_en, e_done;
        logic [63:0] e_bin;
        int          e_rc;
        if (m_sched.size() > 0) begin
            e_rdy = 1'b0; e_en = m_sched[0].en; e_done = m_sched[0].done;
            e_bin = m_sched[0].bin; e_rc = m_sched[0].rc;
        end else begin
            e_rdy = m_matrix; e_en = 1'b0; e_done = 1'b0; e_bin = '0; e_rc = m_rows;
        end
        chk("model_in_ready", 64'(in_ready), 64'(e_rdy));
        chk("model_en", 64'(en), 64'(e_en));
        chk("model_done", 64'(done), 64'(e_done));
        chk("model_Bin", bin, e_bin);
        chk("model_row_cnt", 64'(row_cnt), 64'(e_rc[7:0]));
    endtask

    // Called at a negedge: drive inputs, advance one clock, compare at next negedge.
    task automatic step(input bit r, input bit s, input bit v, input logic [7:0] d);
        rst = r; start = s; in_valid = v; in_data = d;
        model_step(r, s, v, d);
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        bit          start;
        bit          valid;
        logic [7:0]  data;
        bit          rdy;
        bit          en;
        logic [7:0]  rc;
        logic [63:0] bin;
    } vec_t;

    vec_t        tbl[10];
    logic [63:0] row_a;
    logic [63:0] row_b;
    int          n_en;
    bit          seen_done;

    initial begin
        row_a = {8'd4, 8'd3, 8'd2, 8'd1, 8'hFF, 8'h00, 8'h7F, 8'h80};
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 64'd0};
        tbl[1] = '{1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 8'd0, 64'd0};
        tbl[2] = '{1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 8'd0, 64'd0};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 64'd0};
        tbl[4] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'd0, 64'd0};
        tbl[5] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'd0, 64'd0};
        tbl[6] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'd0, 64'd0};
        tbl[7] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'd0, 64'd0};
        tbl[8] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'd0, row_a};
        // Valid data and start held through ISSUE must be ignored.
        tbl[9] = '{1'b1, 1'b1, 8'h4D, 1'b1, 1'b0, 8'd1, 64'd0};

        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'h55);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_en", 64'(en), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_Bin", bin, 64'd0);
        chk("reset_row_cnt", 64'(row_cnt), 64'd0);
        step(1'b0, 1'b0, 1'b1, 8'h11);
        chk("idle_no_start", 64'(in_ready), 64'd0);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl[i].start, tbl[i].valid, tbl[i].data);
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_en", i), 64'(en), 64'(tbl[i].en));
            chk($sformatf("tbl%0d_row_cnt", i), 64'(row_cnt), 64'(tbl[i].rc));
            chk($sformatf("tbl%0d_Bin", i), bin, tbl[i].bin);
        end

        // Second row with in_valid toggling and start held; entries 9..16.
        for (int k = 9; k <= 16; k++) begin
            step(1'b0, 1'b1, 1'b1, 8'(k));
            if (k != 16) step(1'b0, 1'b1, 1'b0, 8'hEE);
        end
        row_b = {8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9};
        chk("row2_issue_Bin", bin, row_b);
        n_en = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (en) n_en++;
            if (done) begin
                seen_done = 1'b1;
                chk("done_row_cnt", 64'(row_cnt), 64'd2);
            end
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("done_seen", 64'(seen_done), 64'd1);
`ifdef B_LOADER_FLUSH_EN
        chk("row2_en_cycles", 64'(n_en), 64'd8);
`else
        chk("row2_en_cycles", 64'(n_en), 64'd1);
`endif
        chk("after_done_idle", 64'(in_ready), 64'd0);
        chk("after_done_row_cnt", 64'(row_cnt), 64'd2);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("restart_row_cnt", 64'(row_cnt), 64'd0);
        chk("restart_in_ready", 64'(in_ready), 64'd1);

        // Reset mid-FILL after 3 accepted entries, then restart from entry 0.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 8'(8'hA0 + k));
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 8'h33);
        chk("midfill_rst_in_ready", 64'(in_ready), 64'd0);
        chk("midfill_rst_en", 64'(en), 64'd0);
        chk("midfill_rst_Bin", bin, 64'd0);
        chk("midfill_rst_row_cnt", 64'(row_cnt), 64'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 21; k <= 28; k++) step(1'b0, 1'b0, 1'b1, 8'(k));
        chk("restart_row_Bin", bin, {8'd28, 8'd27, 8'd26, 8'd25, 8'd24, 8'd23, 8'd22, 8'd21});
        chk("restart_row_en", 64'(en), 64'd1);

        // Random traffic against the reference schedule.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
